// File: rtl/gencon_defs.sv
// Shared gencon types and widths used by the multiplier arbiter.
package gencon_defs;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESPOND = 3'd3,
    FLUSH   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from
// last_owner+1, wrapping; returns a one-hot grant and its index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic          hit_hi;
  logic          hit_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last_owner))) begin
        hit_hi = 1'b1;
        idx_hi = IW'(j);
      end
      if (req[j] && (j <= int'(last_owner))) begin
        hit_lo = 1'b1;
        idx_lo = IW'(j);
      end
    end
    gnt_idx = hit_hi ? idx_hi : idx_lo;
    gnt     = (hit_hi || hit_lo) ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between NREQ requesters, with a
// watchdog that aborts a stuck grant and drains the multiplier before reuse.
module mult_arbiter
  import gencon_defs::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] op1_flat,
  input  logic [DATA_W*NREQ-1:0] op2_flat,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      result,
  output logic                   busy,
  output logic                   mult_start,
  output logic [DATA_W-1:0]      mult_in1,
  output logic [DATA_W-1:0]      mult_in2,
  input  logic [DATA_W-1:0]      mult_out,
  input  logic                   mult_finish
);

  localparam int            IW      = $clog2(NREQ);
  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_t        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     last_owner;
  logic [IW-1:0]     owner_idx;
  logic [NREQ-1:0]   owner_oh;
  logic              err_flag;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op1 = op1_flat[DATA_W*i +: DATA_W];
        sel_op2 = op2_flat[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= IW'(NREQ - 1);
      owner_idx  <= '0;
      owner_oh   <= '0;
      err_flag   <= 1'b0;
      done       <= '0;
      err        <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      mult_in1   <= '0;
      mult_in2   <= '0;
    end else begin
      done       <= '0;
      err        <= '0;
      mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner_oh   <= gnt;
            owner_idx  <= gnt_idx;
            mult_in1   <= sel_op1;
            mult_in2   <= sel_op2;
            mult_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A finish landing on the expiry cycle still counts as success.
          if (mult_finish) begin
            result   <= mult_out;
            err_flag <= 1'b0;
            done     <= owner_oh;
            state    <= RESPOND;
          end else if (cnt == CNT_MAX) begin
            result   <= '0;
            err_flag <= 1'b1;
            done     <= owner_oh;
            err      <= owner_oh;
            state    <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          last_owner <= owner_idx;
          cnt        <= '0;
          if (err_flag) begin
            state <= FLUSH;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FLUSH: begin
          // Drain the aborted operation so its finish cannot hit the next grant.
          if (mult_finish || (cnt == CNT_MAX)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
